imm_narrow_serializer: RTL
==========================

Name: imm_narrow_serializer

Overview:
- Narrowing end of the 8-bit-immediate path. Inverse of the 8-to-16 extender, which pads the upper byte with PAD_BYTE (ones).
- Accepts 16-bit datapath words over a valid/ready handshake and emits them as 8-bit bytes toward the byte-wide immediate/instruction store.
- When the upper byte equals PAD_BYTE, the word is compressible: only the low byte is sent, flagged short, so the extender reproduces it exactly. Otherwise the word goes out as two bytes, low byte first.

Parameters:
- PAD_BYTE, 8'hFF, upper-byte pattern the extender restores; equality with it makes a word compressible.
- ALLOW_SHORT, 1, 1 enables the short form; 0 forces the two-byte form for every word.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts in_word this cycle.
- in_word  input  16  word to narrow.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts out_byte this cycle.
- out_byte  output  8  emitted byte.
- out_last  output  1  final byte of the current word.
- out_short  output  1  word was compressed; qualified by out_valid, high only on its single byte.
- word_count  output  CNT_W  words accepted; saturating.
- short_count  output  CNT_W  words sent in short form; saturating.

Behaviour:
- Reset, synchronous and active-high, sampled on the rising clk edge. All outputs go to 0: out_valid, out_byte, out_last, out_short, word_count, short_count. Also:
  - state = IDLE, holding register = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-word drops the in-flight word and any unsent byte; nothing is emitted afterwards.
- Handshake:
  - Transfer on in_valid&in_ready and on out_valid&out_ready.
  - out_byte, out_last and out_short hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Compressible test: short = ALLOW_SHORT && (in_word[15:8] == PAD_BYTE), evaluated once at acceptance and registered.
- FSM states: IDLE, LO, HI.
  - IDLE: in_ready=1, out_valid=0. On accept, latch in_word and short, then go to LO.
  - LO: out_byte = word[7:0], out_valid=1, out_short = short, out_last = short.
    - On out_ready with short=1: word done.
    - On out_ready with short=0: go to HI.
  - HI: out_byte = word[15:8], out_valid=1, out_last=1, out_short=0. On out_ready: word done.
- Word done: in_ready = out_ready in the completing cycle, a combinational pass-through that gives zero-bubble back-to-back operation.
  - If a new word is accepted in that cycle, next state = LO with the new word.
  - Otherwise next state = IDLE.
- In every other state, in_ready = 0.
- Latency: word accepted at edge N gives its first byte valid in cycle N+1.
- Throughput with out_ready held high:
  - Short words: one per cycle.
  - Long words: one per 2 cycles.
- Counters:
  - word_count increments on each input accept.
  - short_count increments on each accepted short word.
  - Both saturate at all-ones and do not wrap.
- in_word with upper byte = PAD_BYTE but ALLOW_SHORT=0 is sent long: two bytes, out_short=0.
- in_valid while in_ready=0 is ignored. The upstream must hold the word; the block never samples it.

Decomposition:
- Shared package:
  - state enum {IDLE, LO, HI}.
  - PAD_BYTE default constant 8'hFF, also used by the extender so both ends agree.
  - Byte-width and word-width constants: 8 and 16.
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, reset, inc, count), instantiated twice.
- FSM and datapath stay in the top module.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, word_count=0, short_count=0.
- in_word=16'hFF5A, out_ready=1 → next cycle a single byte 8'h5A with out_last=1 and out_short=1. short_count=1, word_count=1.
- in_word=16'h1234, out_ready=1 → bytes 8'h34 (last=0) then 8'h12 (last=1), out_short=0 on both. Then in_ready=1 again.
- Back-to-back 16'hFF01, 16'hFF02, 16'hFF03 with in_valid and out_ready held high → bytes 01, 02, 03 in three consecutive cycles, no bubbles. short_count=3.
- 16'hABCD with out_ready low for 3 cycles → out_byte holds 8'hCD, out_valid stays high, in_ready=0. Release → CD then AB.
- Reset asserted while in HI with word 16'h1234 → out_valid=0 the next cycle, 8'h12 is never emitted, counters are 0. With ALLOW_SHORT=0, 16'hFF5A → 5A then FF, out_short=0.

Source files
------------

// File: rtl/imm_narrow_serializer_pkg.sv
// Shared types and constants for the 16-to-8 immediate narrowing path.
// PAD_BYTE_DEF is also used by the 8-to-16 extender, so both ends agree on padding.
package imm_narrow_serializer_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [BYTE_W-1:0] PAD_BYTE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

endpackage

// File: rtl/imm_narrow_serializer_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imm_narrow_serializer.sv
// Narrows 16-bit words to a byte stream, low byte first.
// Words whose upper byte is the pad pattern go out as one short byte.
module imm_narrow_serializer
    import imm_narrow_serializer_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PAD_BYTE    = PAD_BYTE_DEF,
    parameter bit                ALLOW_SHORT = 1'b1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    output logic              out_short,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  short_count
);

    state_t            state;
    state_t            state_n;
    logic [WORD_W-1:0] word;
    logic              short_q;
    logic              short_in;
    logic              accept;
    logic              done;

    assign short_in = ALLOW_SHORT &&
                      (in_word[WORD_W-1:BYTE_W] == PAD_BYTE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            word    <= '0;
            short_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                word    <= in_word;
                short_q <= short_in;
            end
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        out_short = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = LO;
            end
            LO: begin
                out_valid = 1'b1;
                out_byte  = word[BYTE_W-1:0];
                out_short = short_q;
                out_last  = short_q;
                if (out_ready) begin
                    if (short_q) done = 1'b1;
                    else         state_n = HI;
                end
            end
            HI: begin
                out_valid = 1'b1;
                out_byte  = word[WORD_W-1:BYTE_W];
                out_last  = 1'b1;
                if (out_ready) done = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Completing cycle passes out_ready straight through: no bubble.
        if (done) begin
            in_ready = out_ready;
            state_n  = in_valid ? LO : IDLE;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (word_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_short_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept & short_in),
        .count (short_count)
    );

endmodule
